// File: rtl/jtag_host_pkg.sv
// Shared types for the JTAG host shifter: command opcodes, the TAP state
// encoding used by the host-side tracker, and the sequencer state encoding.
package jtag_host_pkg;

  // Number of TMS=1 bits that force any TAP into Test-Logic-Reset.
  localparam int RESET_TMS_LEN = 5;

  typedef enum logic [1:0] {
    CMD_RESET = 2'b00,
    CMD_IR    = 2'b01,
    CMD_DR    = 2'b10,
    CMD_NOP   = 2'b11
  } cmd_op_e;

  typedef enum logic [3:0] {
    TAP_TLR,      TAP_RTI,
    TAP_SEL_DR,   TAP_CAP_DR,   TAP_SHIFT_DR, TAP_EXIT1_DR,
    TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR,
    TAP_SEL_IR,   TAP_CAP_IR,   TAP_SHIFT_IR, TAP_EXIT1_IR,
    TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
  } tap_state_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RST_SEQ, ST_NAV_IN, ST_SHIFT, ST_NAV_OUT, ST_RESP
  } host_state_e;

  // TAP controller transition taken on a TCK rising edge.
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TAP_TLR:      n = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   n = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: n = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: n = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: n = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: n = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   n = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: n = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: n = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: n = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: n = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   n = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: divides clk while run is high; strobes mark the clk edge on
// which tck will rise or fall so the sequencer can act on the same edge.
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          term;

  assign term     = run && (cnt_q == TERM);
  assign rise_stb = term && !tck_q;
  assign fall_stb = term && tck_q;
  assign tck      = tck_q;

  // Half-period counter; tck parks low whenever the sequencer is not running.
  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!run) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (term) begin
      cnt_d = '0;
      tck_d = !tck_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

endmodule

// File: rtl/jtag_host_shifter.sv
// JTAG host: runs RESET / IR scan / DR scan commands against a TAP, starting
// and ending in Run-Test/Idle, and returns the TDO bits captured in Shift.
module jtag_host_shifter
  import jtag_host_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0] LMAX  = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0] RSTN  = LEN_W'(RESET_TMS_LEN);

  host_state_e       state_q, state_d;
  cmd_op_e           op_q, op_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  tap_state_e        tap_q, tap_d;
  logic              tap_known_q, tap_known_d;

  logic              run, rise_stb, fall_stb;
  logic [LEN_W-1:0]  nav_last;
  cmd_op_e           in_op;

  // Zero-length scans shift one bit; over-long scans clip to the bus width.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
    if (l == '0)  return ONE;
    if (l > LMAX) return LMAX;
    return l;
  endfunction

  assign run      = (state_q == ST_RST_SEQ) || (state_q == ST_NAV_IN) ||
                    (state_q == ST_SHIFT)   || (state_q == ST_NAV_OUT);
  assign nav_last = (op_q == CMD_IR) ? LEN_W'(3) : LEN_W'(2);
  assign in_op    = cmd_op_e'(cmd_op);

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .tck      (tck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  // Sequencer: TMS/TDI advance on falling TCK, TDO is captured on rising TCK.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    mask_d      = mask_q;
    rsp_data_d  = rsp_data_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    tap_d       = tap_q;
    tap_known_d = tap_known_q;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          op_d        = in_op;
          len_d       = sat_len(cmd_len);
          sh_d        = cmd_data;
          mask_d      = DATA_W'(1);
          rsp_data_d  = '0;
          idx_d       = '0;
          tdi_d       = 1'b0;
          if (in_op == CMD_NOP) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
          end else if (in_op == CMD_RESET || !tap_known_q) begin
            // Unknown TAP state: force Test-Logic-Reset before any scan.
            state_d = ST_RST_SEQ;
            tms_d   = 1'b1;
          end else begin
            state_d = ST_NAV_IN;
            tms_d   = 1'b1;
          end
        end
      end
      ST_RST_SEQ: if (fall_stb) begin
        if (idx_q == RSTN) begin
          idx_d = '0;
          if (op_q == CMD_RESET) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            tms_d       = 1'b0;
          end else begin
            state_d = ST_NAV_IN;
            tms_d   = 1'b1;
          end
        end else begin
          idx_d = idx_q + ONE;
          tms_d = (idx_q + ONE) < RSTN;
        end
      end
      ST_NAV_IN: if (fall_stb) begin
        if (idx_q == nav_last) begin
          state_d = ST_SHIFT;
          idx_d   = '0;
          tms_d   = (len_q == ONE);
          tdi_d   = sh_q[0];
        end else begin
          idx_d = idx_q + ONE;
          tms_d = (op_q == CMD_IR) && (idx_q == '0);
        end
      end
      ST_SHIFT: begin
        if (rise_stb) rsp_data_d = rsp_data_q | (mask_q & {DATA_W{tdo}});
        if (fall_stb) begin
          mask_d = mask_q << 1;
          if (idx_q == len_q - ONE) begin
            state_d = ST_NAV_OUT;
            idx_d   = '0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            idx_d = idx_q + ONE;
            sh_d  = sh_q >> 1;
            tdi_d = sh_q[1];
            tms_d = (idx_q + LEN_W'(2)) == len_q;
          end
        end
      end
      ST_NAV_OUT: if (fall_stb) begin
        tms_d = 1'b0;
        if (idx_q == ONE) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          idx_d = ONE;
        end
      end
      ST_RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Host-side TAP tracker; the fifth TMS=1 pins it to Test-Logic-Reset.
    if (rise_stb) begin
      tap_d = tap_next(tap_q, tms_q);
      if (state_q == ST_RST_SEQ && idx_q == RSTN - ONE) begin
        tap_d       = TAP_TLR;
        tap_known_d = 1'b1;
      end
    end
  end

  // Sequencer registers; reset parks outputs and forgets the TAP state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= CMD_NOP;
      len_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      mask_q      <= '0;
      rsp_data_q  <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      tap_q       <= TAP_TLR;
      tap_known_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      mask_q      <= mask_d;
      rsp_data_q  <= rsp_data_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      tap_q       <= tap_d;
      tap_known_q <= tap_known_d;
    end
  end

  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jtag_host_shifter.sv
// Directed bench for jtag_host_shifter with a behavioural TAP target
// (4-bit IR capturing 0001, 1-bit BYPASS on every DR).
module tb_jtag_host_shifter;
  import jtag_host_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [1:0]        cmd_op;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data, rsp_data;
  logic              tck, tms, tdi;
  logic              tdo = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jtag_host_shifter #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  // ---------------- target TAP model ----------------
  tap_state_e m_st = TAP_SHIFT_IR;  // arbitrary power-up state, not TLR
  logic       m_byp = 1'b0;
  logic [3:0] m_ir_sr = 4'h0;
  logic [3:0] m_ir = 4'h0;
  int         m_shdr = 0;
  bit         m_tms_log[$];
  int         m_rise_cyc[$];

  always @(posedge tck) begin
    tap_state_e nx;
    m_tms_log.push_back(tms);
    m_rise_cyc.push_back(cyc);
    case (m_st)
      TAP_TLR:      nx = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      nx = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   nx = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   nx = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: nx = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: nx = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: nx = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: nx = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   nx = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_IR:   nx = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_IR:   nx = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: nx = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: nx = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: nx = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: nx = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      default:      nx = tms ? TAP_SEL_DR   : TAP_RTI;
    endcase
    if (m_st == TAP_CAP_DR)   m_byp <= 1'b0;
    if (m_st == TAP_SHIFT_DR) m_byp <= tdi;
    if (m_st == TAP_CAP_IR)   m_ir_sr <= 4'b0001;
    if (m_st == TAP_SHIFT_IR) m_ir_sr <= {tdi, m_ir_sr[3:1]};
    if (m_st != TAP_SHIFT_DR && nx == TAP_SHIFT_DR) m_shdr <= m_shdr + 1;
    m_st <= nx;
  end

  always @(negedge tck) begin
    tdo <= (m_st == TAP_SHIFT_DR) ? m_byp :
           (m_st == TAP_SHIFT_IR) ? m_ir_sr[0] : 1'b0;
    if (m_st == TAP_UPD_IR) m_ir <= m_ir_sr;
  end

  // ---------------- helpers ----------------
  int base_e    = 0;
  int base_shdr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int edges();
    return m_tms_log.size() - base_e;
  endfunction

  function automatic logic [63:0] tms_vec();
    logic [63:0] v = '0;
    for (int i = base_e; i < m_tms_log.size() && i - base_e < 64; i++)
      v[i - base_e] = m_tms_log[i];
    return v;
  endfunction

  task automatic send(input logic [1:0] op, input int len, input logic [31:0] data);
    base_e    = m_tms_log.size();
    base_shdr = m_shdr;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    chk("cmd_ready before send", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " rsp_valid"}, rsp_valid, 1);
    chk({tag, " parked tck/tms/tdi"}, {tck, tms, tdi}, 3'b000);
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " ready after rsp"}, {cmd_ready, rsp_valid}, 2'b10);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = '0; cmd_data = '0; rsp_ready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst outputs", {tck, tms, tdi, cmd_ready, rsp_valid}, 5'b01000);
    chk("rst rsp_data", rsp_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready after rst", cmd_ready, 1);

    // DR scan with unknown tracker: auto RESET prefix then DR through BYPASS
    send(2'b10, 8, 32'hA5);
    wait_rsp("auto");
    chk("auto edges", edges(), 19);
    chk("auto tms", tms_vec(), 64'h3005F);
    chk("auto shift-dr entries", m_shdr - base_shdr, 1);
    chk("auto rsp_data", rsp_data, 32'h4A);
    chk("auto model rti", m_st, TAP_RTI);
    consume("auto");

    // RESET command
    send(2'b00, 0, 32'h0);
    chk("reset first bit", {tck, tms}, 2'b01);
    wait_rsp("reset");
    chk("reset edges", edges(), 6);
    chk("reset tms", tms_vec(), 64'h1F);
    chk("reset spacing", m_rise_cyc[m_rise_cyc.size()-1] - m_rise_cyc[base_e], 20);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset model rti", m_st, TAP_RTI);
    consume("reset");

    // DR scan, tracker known
    send(2'b10, 8, 32'hA5);
    wait_rsp("dr8");
    chk("dr8 edges", edges(), 13);
    chk("dr8 tms", tms_vec(), 64'hC01);
    chk("dr8 shift-dr entries", m_shdr - base_shdr, 1);
    chk("dr8 rsp_data", rsp_data, 32'h4A);
    consume("dr8");

    // IR scan
    send(2'b01, 4, 32'h1);
    wait_rsp("ir4");
    chk("ir4 edges", edges(), 10);
    chk("ir4 tms", tms_vec(), 64'h183);
    chk("ir4 rsp_data", rsp_data, 32'h1);
    chk("ir4 model ir", m_ir, 4'h1);
    chk("ir4 model rti", m_st, TAP_RTI);
    consume("ir4");

    // Response backpressure
    send(2'b10, 16, 32'h1234);
    wait_rsp("bp");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp hold", {rsp_valid, cmd_ready, tck, rsp_data}, {3'b100, 32'h2468});
    end
    consume("bp");

    // NOP: immediate response, no TCK activity
    send(2'b11, 5, 32'hFFFF);
    chk("nop immediate rsp", rsp_valid, 1);
    wait_rsp("nop");
    chk("nop edges", edges(), 0);
    chk("nop rsp_data", rsp_data, 0);
    consume("nop");

    // len=0 behaves as len=1
    send(2'b10, 0, 32'h1);
    wait_rsp("len0");
    chk("len0 edges", edges(), 6);
    chk("len0 tms", tms_vec(), 64'h19);
    chk("len0 rsp_data", rsp_data, 0);
    consume("len0");

    // len>DATA_W saturates
    send(2'b10, 40, 32'hFFFFFFFF);
    wait_rsp("len40");
    chk("len40 edges", edges(), 37);
    chk("len40 tms", tms_vec(), 64'h0000000C_00000001);
    chk("len40 rsp_data", rsp_data, 32'hFFFFFFFE);
    consume("len40");

    // Reset in the middle of a 32-bit DR shift
    send(2'b10, 32, 32'hDEADBEEF);
    for (int i = 0; i < 500 && m_st != TAP_SHIFT_DR; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("mid model in shift", m_st, TAP_SHIFT_DR);
    rst = 1'b1;
    #1;
    chk("mid rst outputs", {tck, tms, rsp_valid, cmd_ready}, 4'b0100);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid no rsp", rsp_valid, 0);
    send(2'b10, 8, 32'hA5);
    wait_rsp("post");
    chk("post edges", edges(), 19);
    chk("post tms", tms_vec(), 64'h3005F);
    chk("post shift-dr entries", m_shdr - base_shdr, 1);
    chk("post rsp_data", rsp_data, 32'h4A);
    consume("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
